// File: rtl/result_write_controller_pkg.sv
// Shared softmax pipeline definitions: write-controller FSM states,
// default geometry and the frame-length clamp.
package softmax_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wr_state_e;

    // A zero length or one beyond the RAM size means "fill the whole RAM".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned depth);
        if (len == 0 || len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/result_write_controller_if.sv
// Result stream handshake plus RAM write port of the result write controller.
interface result_write_controller_if
    import softmax_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/result_write_controller_wr_addr_counter.sv
// Write address counter: load clears the count and latches the frame length,
// enable advances it, tc_o flags the final address of the frame.
module wr_addr_counter #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              tc_o
);
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W:0]   len_q;

    // Count stops at the terminal value so a full-depth frame never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            len_q <= len_i;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + ADDR_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = ({1'b0, cnt_q} == (len_q - (ADDR_W+1)'(1)));

endmodule

// File: rtl/result_write_controller.sv
// Result write controller: writes a framed stream of softmax results to
// consecutive RAM addresses from 0, with registered write port and
// start/busy/done framing.
// Optional feature macro: RESULT_WR_OVF_EN adds the sticky overflow flag.
module result_write_controller
    import softmax_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W:0]         frame_len,
    result_write_controller_if.slave bus,
    output logic                    busy,
    output logic                    done
`ifdef RESULT_WR_OVF_EN
    ,
    output logic                    overflow
`endif
);
    wr_state_e         state_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              busy_q;
    logic              done_q;

    logic              load;
    logic              handshake;
    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W-1:0] cnt;
    logic              tc;

    assign bus.in_ready = (state_q == WRITE);
    assign handshake    = bus.in_valid && (state_q == WRITE);
    assign load         = (state_q == IDLE) && start;
    assign eff_len      = (ADDR_W+1)'(clamp_len(32'(frame_len), DEPTH));

    wr_addr_counter #(
        .ADDR_W(ADDR_W)
    ) u_wr_addr_counter (
        .clk_i (clock),
        .rst_ni(reset_n),
        .load_i(load),
        .len_i (eff_len),
        .en_i  (handshake),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // Frame FSM with registered write port and framing outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WRITE;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (handshake) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt;
                        wr_data_q <= bus.in_data;
                        if (tc) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef RESULT_WR_OVF_EN
    logic ovf_q;

    // Sticky flag for words offered while no frame is accepting them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid && !bus.in_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_result_write_controller.sv
// Self-checking bench for result_write_controller.
module tb_result_write_controller;
    import softmax_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    typedef struct {
        logic [AW:0]   len;
        logic [15:0]   pat;      // in_valid pattern, bit = cycle index mod 16
        logic [15:0]   base;     // data of word k is base + k
        int            ign_at;   // word index at which a stray start is pulsed, -1 none
        int            exp_len;  // expected number of writes
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [AW:0]   frame_len;
    logic          busy;
    logic          done;
`ifdef RESULT_WR_OVF_EN
    logic          overflow;
`endif

    int            n_vec;
    int            n_miss;
    int            done_cnt;
    exp_t          exp_q[$];
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    vec_t          vecs[6];

    result_write_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    result_write_controller #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (1024)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .frame_len(frame_len),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
`ifdef RESULT_WR_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every write must match the scoreboard head;
    // idle cycles must hold the last written address/data.
    initial begin
        hold_addr = '0;
        hold_data = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                hold_addr = '0;
                hold_data = '0;
            end else if (bus.wr_en) begin
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                    chk("done_with_last", 32'(done), 32'(e.last));
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
                if (done) done_cnt++;
            end else begin
                chk("hold_addr", 32'(bus.wr_addr), 32'(hold_addr));
                chk("hold_data", 32'(bus.wr_data), 32'(hold_data));
                chk("done_without_write", 32'(done), 0);
            end
        end
    end

    // Called #1 after a rising edge with the DUT in IDLE.
    task automatic run_frame(input vec_t v);
        int  cnt;
        int  cyc;
        int  done0;
        bit  ign_done;
        logic vbit;
        cnt = 0;
        cyc = 0;
        ign_done = 0;
        done0 = done_cnt;
        start = 1'b1;
        frame_len = v.len;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_rise", 32'(busy), 1);
`ifdef RESULT_WR_OVF_EN
        chk("ovf_clear_on_start", 32'(overflow), 0);
`endif
        while (cnt < v.exp_len && cyc < v.exp_len * 4 + 64) begin
            chk("in_ready_write", 32'(bus.in_ready), 1);
            vbit = v.pat[cyc % 16];
            if (v.ign_at >= 0 && !ign_done && vbit && cnt == v.ign_at) begin
                start = 1'b1;
                frame_len = 11'd2;
                ign_done = 1;
            end
            bus.in_valid = vbit;
            bus.in_data  = vbit ? 16'(v.base + 16'(cnt)) : 16'hDEAD;
            if (vbit) begin
                exp_q.push_back('{addr: AW'(cnt), data: 16'(v.base + 16'(cnt)),
                                  last: (cnt == v.exp_len - 1)});
                cnt++;
            end
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (cnt != v.exp_len) chk("frame_timeout", 32'(cnt), 32'(v.exp_len));
        chk("in_ready_done", 32'(bus.in_ready), 0);
        chk("busy_in_done", 32'(busy), 1);
        @(posedge clock); #1;
        chk("done_count", 32'(done_cnt - done0), 1);
        chk("busy_fall", 32'(busy), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        done_cnt = 0;
        //          len     pat       base      ign  exp
        vecs[0] = '{11'd4,    16'hFFFF, 16'h00A0, -1, 4};
        vecs[1] = '{11'd3,    16'h0029, 16'h00B0, -1, 3};
        vecs[2] = '{11'd0,    16'hFFFF, 16'h1000, -1, 1024};
        vecs[3] = '{11'd1025, 16'hFFFF, 16'h2000, -1, 1024};
        vecs[4] = '{11'd6,    16'hFFFF, 16'h0060,  2, 6};
        vecs[5] = '{11'd1,    16'hFFFF, 16'h0077, -1, 1};

        reset_n = 1'b1;
        start = 1'b0;
        frame_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef RESULT_WR_OVF_EN
        chk("rst_overflow", 32'(overflow), 0);
`endif
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end

        // Word offered while idle: never written; flags overflow when enabled.
        bus.in_valid = 1'b1;
        bus.in_data = 16'h5555;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
`ifdef RESULT_WR_OVF_EN
        chk("ovf_set", 32'(overflow), 1);
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", 32'(busy), 0);
`ifdef RESULT_WR_OVF_EN
        chk("ovf_sticky", 32'(overflow), 1);
`endif
        run_frame(vecs[0]);

        // Reset in the middle of an 8-word frame, during word 5.
        start = 1'b1;
        frame_len = 11'd8;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(16'h00C0 + 16'(i));
            exp_q.push_back('{addr: AW'(i), data: 16'(16'h00C0 + 16'(i)), last: 1'b0});
            @(posedge clock); #1;
        end
        #1;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
        chk("mid_rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("mid_rst_wr_data", 32'(bus.wr_data), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef RESULT_WR_OVF_EN
        chk("mid_rst_overflow", 32'(overflow), 0);
`endif
        exp_q.delete();
        begin
            int done0;
            done0 = done_cnt;
            @(posedge clock); #1;
            reset_n = 1'b1;
            repeat (12) @(posedge clock);
            #1;
            chk("no_done_after_reset", 32'(done_cnt - done0), 0);
            chk("idle_after_reset", 32'(busy), 0);
        end
        run_frame(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/result_write_controller.md
# result_write_controller

Write-side address/control generator for the softmax pipeline's output buffer. It accepts a stream of softmax result words over a valid/ready handshake and writes them into a single-port result RAM of `DEPTH` entries at consecutive addresses starting at 0. It is the writing counterpart to the free-running read address generator that feeds the input RAM. It frames each pass with `start`, `busy` and `done`, so the top-level controller knows when a full result vector has landed.

## Interface
- `ADDR_W`, 10: RAM address width.
- `DATA_W`, 16: result word width.
- `DEPTH`, 1024: RAM entries. Must satisfy `DEPTH` ≤ 2^`ADDR_W`.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `frame_len` in `ADDR_W`+1: number of words in the frame; sampled with `start`.
- `in_valid` in 1: result word available.
- `in_data` in `DATA_W`: result word.
- `in_ready` out 1: controller accepts a word this cycle.
- `wr_en` out 1: RAM write enable, registered.
- `wr_addr` out `ADDR_W`: RAM write address, registered.
- `wr_data` out `DATA_W`: RAM write data, registered.
- `busy` out 1: high in WRITE and DONE.
- `done` out 1: one-cycle pulse at frame completion.
- `overflow` out 1: sticky error flag; present only with `RESULT_WR_OVF_EN`.

## Operation
- **States:** IDLE, WRITE, DONE.
- **Reset:** state IDLE. `in_ready`, `wr_en`, `busy`, `done`, `overflow` are 0. `wr_addr` is 0 and `wr_data` is 0.
- **IDLE:**
  - `in_ready` = 0.
  - On `start` = 1: latch the effective length and clear the address counter to 0, then go to WRITE.
  - Effective length is `frame_len`, except that 0 or any value > `DEPTH` clamps to `DEPTH`.
- **WRITE:**
  - `in_ready` = 1 (combinational from state).
  - Each handshake (`in_valid` && `in_ready`) registers `wr_en`=1, `wr_addr`=counter and `wr_data`=`in_data`, then increments the counter.
  - Cycles with no handshake give `wr_en`=0 next cycle; `wr_addr` and `wr_data` hold their values.
  - The handshake at counter = length−1 moves the state to DONE.
- **DONE:**
  - Lasts exactly one cycle, with `done`=1 and `in_ready`=0, then returns to IDLE.
- **Ignored `start`:** `start` in WRITE or DONE is ignored, with no restart and no relatch.
- **No wrap:** the counter never wraps within a frame, because the length is ≤ `DEPTH`. The next frame restarts at address 0.
- **Reset mid-frame:** returns to IDLE immediately with all outputs at reset values. The partial frame is abandoned and no `done` is issued.

## Timing
- Handshake to write latency is 1 cycle. A word accepted at edge t appears on `wr_*` during the cycle after edge t.
- Throughput is one word per cycle in WRITE.
- The last word's `wr_en`=1 and `done`=1 are asserted in the same cycle; state is DONE in that cycle.
- The earliest next `start` is accepted in the cycle after `done`.
- `busy` is registered and rises the cycle after `start` is sampled.
- A frame of length L with `in_valid` held high takes L+1 cycles from `start` to `done`, inclusive of the DONE cycle.

## Configuration
- **`RESULT_WR_OVF_EN` defined:**
  - `overflow` port exists.
  - It sets when `in_valid`=1 while `in_ready`=0 in IDLE or DONE, meaning the producer is running ahead of the frame.
  - It stays set until `start` is accepted or reset.
- **`RESULT_WR_OVF_EN` undefined:** the port and its logic are absent. Such words are silently unaccepted.

## Structure
- **Shared package `softmax_pkg`:**
  - state enum (IDLE, WRITE, DONE);
  - default `ADDR_W`/`DATA_W`/`DEPTH` constants;
  - the length-clamp function.
- **Sub-module `wr_addr_counter`:** clear/enable counter of `ADDR_W` bits with a terminal-count compare against the latched length. The FSM and output registers stay in the top.

## Test plan
- **Reset:** assert `reset_n`=0 mid-frame at word 5 of 8. Require all outputs 0 and state IDLE asynchronously, and no `done` afterwards.
- **Short frame:** `frame_len`=4 with `in_valid` held high and data 0xA0..0xA3. Require `wr_addr` 0,1,2,3 on consecutive cycles with matching data, and `done` in the same cycle as address 3.
- **Bubbles:** `frame_len`=3 with `in_valid` pattern 1,0,0,1,0,1. Require exactly 3 `wr_en` pulses at addresses 0,1,2, each one cycle after its handshake.
- **Full depth / clamp:** `frame_len`=0, then 1025. Each is treated as 1024. Require a final write at address 1023, then `done`, with no address 0 rewrite.
- **Ignored start:** pulse `start` during WRITE at word 2 of 6. Require the count to continue to 6 and a single `done`.
- **Overflow (`RESULT_WR_OVF_EN`):** `in_valid`=1 in IDLE. Require `overflow`=1 the next cycle, held through idle, and cleared the cycle after `start` is accepted.
